// File: rtl/isa_pkg.sv
// ---------------------------------------------------------------------------
// isa_pkg
//   Shared definitions for the custom MIPS-style ISA used by the pipeline:
//   instruction field bit positions, opcode constants, the 4-bit ALU command
//   encoding, the ID/EX payload record and a sign-extension helper.
// ---------------------------------------------------------------------------
package isa_pkg;

  // Instruction field bit positions
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS1_MSB = 25;
  localparam int RS1_LSB = 21;
  localparam int F2_MSB  = 20;
  localparam int F2_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Opcodes
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  // ALU command encoding seen by EX
  typedef enum logic [3:0] {
    CMD_ADD = 4'd0,
    CMD_SUB = 4'd1,
    CMD_AND = 4'd2,
    CMD_OR  = 4'd3,
    CMD_NOR = 4'd4,
    CMD_XOR = 4'd5,
    CMD_SLA = 4'd6,
    CMD_SLL = 4'd7,
    CMD_SRA = 4'd8,
    CMD_SRL = 4'd9
  } alu_cmd_e;

  // Everything ID hands to EX
  typedef struct packed {
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st_val;
    logic [4:0]  dest;
    alu_cmd_e    cmd;
    logic        wb_en;
    logic        mem_r;
    logic        mem_w;
  } id_ex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   32 x 32-bit register file: two combinational read ports, one write port.
//   r0 always reads 0 and is never written. A read of the register being
//   written in the same cycle returns the incoming write data (write-first),
//   so ID sees the write-back result without an extra cycle.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset (clears all regs)
//   i_rd_addr1/2    read addresses
//   o_rd_data1/2    read data (combinational, bypassed)
//   i_wr_en         write enable
//   i_wr_addr       write address
//   i_wr_data       write data
// ---------------------------------------------------------------------------
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_rd_addr1,
  input  logic [4:0]  i_rd_addr2,
  output logic [31:0] o_rd_data1,
  output logic [31:0] o_rd_data2,
  input  logic        i_wr_en,
  input  logic [4:0]  i_wr_addr,
  input  logic [31:0] i_wr_data
);

  logic [31:0] r_mem [32];
  logic        w_wr_live;

  // A write to r0 is dropped, so it must not bypass either.
  assign w_wr_live = i_wr_en && (i_wr_addr != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data1 = (i_rd_addr1 == 5'd0)                    ? 32'd0     :
                      (w_wr_live && i_rd_addr1 == i_wr_addr)  ? i_wr_data :
                                                                r_mem[i_rd_addr1];

  assign o_rd_data2 = (i_rd_addr2 == 5'd0)                    ? 32'd0     :
                      (w_wr_live && i_rd_addr2 == i_wr_addr)  ? i_wr_data :
                                                                r_mem[i_rd_addr2];

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//   Instruction-decode stage. Holds the IF/ID register, the register file
//   (via reg_file) and the ID/EX register. Decodes the custom ISA and
//   resolves BEZ/BNE/JMP in ID, returning the redirect to fetch
//   combinationally. A taken branch flushes the one wrong-path fetch by
//   loading a NOP into IF/ID on the following edge.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_pc, if_instr          fetched PC / instruction
//   wb_en, wb_dest, wb_value register-file write-back port
//   br_taken, br_addr        branch redirect to fetch (combinational)
//   ex_pc .. ex_mem_w        registered ID/EX outputs
// ---------------------------------------------------------------------------
module id_stage
  import isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic        br_taken,
  output logic [31:0] br_addr,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_val1,
  output logic [31:0] ex_val2,
  output logic [31:0] ex_st_val,
  output logic [4:0]  ex_dest,
  output logic [3:0]  ex_cmd,
  output logic        ex_wb_en,
  output logic        ex_mem_r,
  output logic        ex_mem_w
);

  // IF/ID register
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;

  // ID/EX register
  logic [31:0] r_ex_pc;
  id_ex_t      r_ex;

  // Instruction fields of the instruction in ID
  logic [5:0]  w_op;
  logic [4:0]  w_rs1;
  logic [4:0]  w_f2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_ext;

  // Register-file read data (already bypassed)
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  // Decode results
  id_ex_t      w_dec;
  logic        w_br_taken;
  logic [31:0] w_br_addr;

  assign w_op      = r_id_instr[OP_MSB:OP_LSB];
  assign w_rs1     = r_id_instr[RS1_MSB:RS1_LSB];
  assign w_f2      = r_id_instr[F2_MSB:F2_LSB];
  assign w_rd      = r_id_instr[RD_MSB:RD_LSB];
  assign w_imm_ext = sext16(r_id_instr[IMM_MSB:IMM_LSB]);

  reg_file u_reg_file (
    .clk        (clk),
    .rst        (rst),
    .i_rd_addr1 (w_rs1),
    .i_rd_addr2 (w_f2),
    .o_rd_data1 (w_rd1),
    .o_rd_data2 (w_rd2),
    .i_wr_en    (wb_en),
    .i_wr_addr  (wb_dest),
    .i_wr_data  (wb_value)
  );

  // Target is PC-relative in words; 32-bit wrap-around is intended.
  assign w_br_addr = r_id_pc + 32'd4 + (w_imm_ext << 2);

  always_comb begin
    w_dec.val1   = '0;
    w_dec.val2   = '0;
    w_dec.st_val = '0;
    w_dec.dest   = '0;
    w_dec.cmd    = CMD_ADD;
    w_dec.wb_en  = 1'b0;
    w_dec.mem_r  = 1'b0;
    w_dec.mem_w  = 1'b0;
    w_br_taken   = 1'b0;

    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
      OP_XOR, OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
        w_dec.val1  = w_rd1;
        w_dec.val2  = w_rd2;
        w_dec.dest  = w_rd;
        w_dec.wb_en = 1'b1;
        case (w_op)
          OP_SUB:  w_dec.cmd = CMD_SUB;
          OP_AND:  w_dec.cmd = CMD_AND;
          OP_OR:   w_dec.cmd = CMD_OR;
          OP_NOR:  w_dec.cmd = CMD_NOR;
          OP_XOR:  w_dec.cmd = CMD_XOR;
          OP_SLA:  w_dec.cmd = CMD_SLA;
          OP_SLL:  w_dec.cmd = CMD_SLL;
          OP_SRA:  w_dec.cmd = CMD_SRA;
          OP_SRL:  w_dec.cmd = CMD_SRL;
          default: w_dec.cmd = CMD_ADD;
        endcase
      end
      OP_ADDI, OP_SUBI: begin
        w_dec.val1  = w_rd1;
        w_dec.val2  = w_imm_ext;
        w_dec.dest  = w_f2;
        w_dec.wb_en = 1'b1;
        w_dec.cmd   = (w_op == OP_SUBI) ? CMD_SUB : CMD_ADD;
      end
      OP_LD: begin
        w_dec.val1  = w_rd1;
        w_dec.val2  = w_imm_ext;
        w_dec.dest  = w_f2;
        w_dec.wb_en = 1'b1;
        w_dec.mem_r = 1'b1;
      end
      OP_ST: begin
        // f2 names the store-data register here, not a destination
        w_dec.val1   = w_rd1;
        w_dec.val2   = w_imm_ext;
        w_dec.st_val = w_rd2;
        w_dec.mem_w  = 1'b1;
      end
      OP_BEZ: w_br_taken = (w_rd1 == 32'd0);
      OP_BNE: w_br_taken = (w_rd1 != w_rd2);
      OP_JMP: w_br_taken = 1'b1;
      OP_NOP: ;  // bubble: defaults
      default: ; // undefined opcodes also decode as a bubble
    endcase
  end

  assign br_taken = w_br_taken;
  assign br_addr  = w_br_addr;

  // IF/ID: a taken branch in ID kills the instruction fetched behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_pc    <= '0;
      r_id_instr <= '0;
    end else begin
      r_id_pc    <= if_pc;
      r_id_instr <= w_br_taken ? 32'd0 : if_instr;
    end
  end

  // ID/EX: no stall path, loads every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_pc      <= '0;
      r_ex.val1    <= '0;
      r_ex.val2    <= '0;
      r_ex.st_val  <= '0;
      r_ex.dest    <= '0;
      r_ex.cmd     <= CMD_ADD;
      r_ex.wb_en   <= 1'b0;
      r_ex.mem_r   <= 1'b0;
      r_ex.mem_w   <= 1'b0;
    end else begin
      r_ex_pc <= r_id_pc;
      r_ex    <= w_dec;
    end
  end

  assign ex_pc     = r_ex_pc;
  assign ex_val1   = r_ex.val1;
  assign ex_val2   = r_ex.val2;
  assign ex_st_val = r_ex.st_val;
  assign ex_dest   = r_ex.dest;
  assign ex_cmd    = r_ex.cmd;
  assign ex_wb_en  = r_ex.wb_en;
  assign ex_mem_r  = r_ex.mem_r;
  assign ex_mem_w  = r_ex.mem_w;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
//   Self-checking bench for id_stage: directed scenarios plus randomized
//   traffic checked against an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_value;
  logic        br_taken;
  logic [31:0] br_addr;
  logic [31:0] ex_pc;
  logic [31:0] ex_val1;
  logic [31:0] ex_val2;
  logic [31:0] ex_st_val;
  logic [4:0]  ex_dest;
  logic [3:0]  ex_cmd;
  logic        ex_wb_en;
  logic        ex_mem_r;
  logic        ex_mem_w;

  int n_cmp  = 0;
  int n_fail = 0;

  id_stage dut (
    .clk       (clk),
    .rst       (rst),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .wb_en     (wb_en),
    .wb_dest   (wb_dest),
    .wb_value  (wb_value),
    .br_taken  (br_taken),
    .br_addr   (br_addr),
    .ex_pc     (ex_pc),
    .ex_val1   (ex_val1),
    .ex_val2   (ex_val2),
    .ex_st_val (ex_st_val),
    .ex_dest   (ex_dest),
    .ex_cmd    (ex_cmd),
    .ex_wb_en  (ex_wb_en),
    .ex_mem_r  (ex_mem_r),
    .ex_mem_w  (ex_mem_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------
  // Reference model: architectural registers, the instruction sitting in
  // ID, and the expected contents of EX with a mask of defined fields.
  // ------------------------------------------------------------------
  typedef struct {
    logic [31:0] val1, val2, st_val;
    logic [4:0]  dest;
    logic [3:0]  cmd;
    logic        wb_en, mem_r, mem_w;
    bit          chk_val1, chk_val2, chk_st, chk_dest, chk_cmd;
  } exp_t;

  logic [31:0] m_regs [32];
  logic [31:0] m_id_pc;
  logic [31:0] m_id_instr;
  exp_t        m_ex;

  function automatic exp_t exp_bubble();
    exp_t e;
    e.val1 = 0; e.val2 = 0; e.st_val = 0; e.dest = 0; e.cmd = 0;
    e.wb_en = 0; e.mem_r = 0; e.mem_w = 0;
    e.chk_val1 = 0; e.chk_val2 = 0; e.chk_st = 0;
    e.chk_dest = 1; e.chk_cmd = 1;
    return e;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_id_pc    = 0;
    m_id_instr = 0;
    m_ex       = exp_bubble();
  endtask

  // Architectural read as seen during the current cycle (write-first).
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 0;
    if (wb_en && wb_dest == a) return wb_value;
    return m_regs[a];
  endfunction

  function automatic exp_t m_decode(input logic [31:0] ins);
    exp_t e;
    int   op, simm;
    logic [4:0] rs1, f2, rd;
    e    = exp_bubble();
    op   = int'(ins[31:26]);
    rs1  = ins[25:21];
    f2   = ins[20:16];
    rd   = ins[15:11];
    simm = $signed(ins[15:0]);
    if (op == 1 || op == 3 || (op >= 5 && op <= 12)) begin
      e.val1 = m_read(rs1); e.val2 = m_read(f2); e.dest = rd; e.wb_en = 1;
      e.cmd  = (op == 1) ? 4'd0 : (op == 3) ? 4'd1 : 4'(op - 3);
      e.chk_val1 = 1; e.chk_val2 = 1;
    end else if (op == 32 || op == 33) begin
      e.val1 = m_read(rs1); e.val2 = 32'(simm); e.dest = f2; e.wb_en = 1;
      e.cmd  = 4'(op - 32);
      e.chk_val1 = 1; e.chk_val2 = 1;
    end else if (op == 36) begin
      e.val1 = m_read(rs1); e.val2 = 32'(simm); e.dest = f2; e.cmd = 0;
      e.wb_en = 1; e.mem_r = 1;
      e.chk_val1 = 1; e.chk_val2 = 1;
    end else if (op == 37) begin
      e.val1 = m_read(rs1); e.val2 = 32'(simm); e.st_val = m_read(f2);
      e.cmd = 0; e.mem_w = 1;
      e.chk_val1 = 1; e.chk_val2 = 1; e.chk_st = 1; e.chk_dest = 0;
    end else if (op >= 40 && op <= 42) begin
      e.chk_dest = 0; e.chk_cmd = 0;
    end
    return e;
  endfunction

  function automatic logic m_br_taken();
    int op;
    op = int'(m_id_instr[31:26]);
    if (op == 40) return m_read(m_id_instr[25:21]) == 0;
    if (op == 41) return m_read(m_id_instr[25:21]) != m_read(m_id_instr[20:16]);
    return op == 42;
  endfunction

  function automatic logic [31:0] m_br_addr();
    int simm;
    simm = $signed(m_id_instr[15:0]);
    return m_id_pc + 32'd4 + 32'(simm * 4);
  endfunction

  // One clock: model evaluates with the inputs currently applied, then the
  // DUT takes the edge; returns 1 ns after the edge.
  task automatic tick();
    exp_t        nx;
    logic        tk, do_w;
    logic [4:0]  wd;
    logic [31:0] wv, npc, nins;
    nx   = m_decode(m_id_instr);
    tk   = m_br_taken();
    npc  = if_pc;
    nins = tk ? 32'd0 : if_instr;
    do_w = wb_en && wb_dest != 0;
    wd   = wb_dest;
    wv   = wb_value;
    @(posedge clk);
    #1;
    m_ex       = nx;
    m_id_pc    = npc;
    m_id_instr = nins;
    if (do_w) m_regs[wd] = wv;
  endtask

  function automatic logic [31:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return {6'(op), 5'(rs1), 5'(rs2), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int f2, input int rs1, input int imm);
    return {6'(op), 5'(rs1), 5'(f2), 16'(imm)};
  endfunction

  task automatic wb_set(input logic en, input int dest, input logic [31:0] val);
    wb_en = en; wb_dest = 5'(dest); wb_value = val;
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    // Load every register so that a cleared register is distinguishable.
    for (int k = 1; k < 32; k++) begin
      wb_set(1, k, 32'(k + 100));
      tick();
    end
    wb_set(0, 0, 0);
    if_pc = 32'd64; if_instr = enc_i(42, 0, 0, 5);
    tick();
    if_instr = 0;
    n_cmp++;
    if (br_taken !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_jmp br_taken got=%0b exp=1", br_taken);
    end
    #2 rst = 1'b1;
    #1;
    m_reset();
    $display("reset asserted mid-cycle with JMP in ID");
    n_cmp++;
    if (br_taken !== 1'b0) begin
      n_fail++; $display("FAIL rst_br_taken got=%0b exp=0", br_taken);
    end
    n_cmp++;
    if ({ex_pc, ex_val1, ex_val2, ex_st_val} !== 128'd0) begin
      n_fail++; $display("FAIL rst_ex_data got=%h_%h_%h_%h exp=0", ex_pc, ex_val1, ex_val2, ex_st_val);
    end
    n_cmp++;
    if ({ex_dest, ex_cmd, ex_wb_en, ex_mem_r, ex_mem_w} !== 12'd0) begin
      n_fail++; $display("FAIL rst_ex_ctrl got=%h exp=0", {ex_dest, ex_cmd, ex_wb_en, ex_mem_r, ex_mem_w});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    // Read back R[1..31] through operand 1 and operand 2.
    for (int k = 1; k <= 32; k++) begin
      if_instr = (k < 32) ? enc_r(1, 0, k, k) : 32'd0;
      tick();
      if (k >= 2) begin
        n_cmp++;
        if (ex_val1 !== m_ex.val1 || ex_val2 !== m_ex.val2 || ex_val1 !== 32'd0) begin
          n_fail++; $display("FAIL rst_readback r%0d got=%h/%h exp=0", k - 1, ex_val1, ex_val2);
        end
      end
    end
    $display("reset readback of r1..r31 done");
  endtask

  task automatic test_addi();
    if_pc = 32'd8; if_instr = 32'h8001060A;
    tick();
    if_instr = 0;
    tick();
    $display("ADDI r1,r0,1546: val1=%0d val2=%0d dest=%0d cmd=%0d wb=%0b", ex_val1, ex_val2, ex_dest, ex_cmd, ex_wb_en);
    n_cmp++;
    if (ex_val1 !== 32'd0 || ex_val2 !== 32'd1546) begin
      n_fail++; $display("FAIL addi_vals got=%0d/%0d exp=0/1546", ex_val1, ex_val2);
    end
    n_cmp++;
    if (ex_dest !== 5'd1 || ex_cmd !== 4'd0 || ex_wb_en !== 1'b1 || ex_mem_r !== 1'b0 || ex_mem_w !== 1'b0) begin
      n_fail++; $display("FAIL addi_ctrl got=d%0d c%0d w%0b r%0b m%0b exp=d1 c0 w1 r0 m0", ex_dest, ex_cmd, ex_wb_en, ex_mem_r, ex_mem_w);
    end
    n_cmp++;
    if (ex_pc !== 32'd8) begin
      n_fail++; $display("FAIL addi_pc got=%0d exp=8", ex_pc);
    end
  endtask

  task automatic test_bypass();
    if_instr = enc_r(1, 2, 0, 1);   // ADD r2,r0,r1
    tick();
    if_instr = 0;
    wb_set(1, 1, 32'd1546);
    tick();
    wb_set(0, 0, 0);
    $display("bypass ADD r2,r0,r1 with wb r1=1546: val2=%0d", ex_val2);
    n_cmp++;
    if (ex_val2 !== 32'd1546 || ex_val1 !== 32'd0 || ex_dest !== 5'd2) begin
      n_fail++; $display("FAIL bypass_val2 got=%0d/%0d d%0d exp=0/1546 d2", ex_val1, ex_val2, ex_dest);
    end
    // No bypass from a write to r0.
    if_instr = enc_r(1, 2, 0, 0);
    tick();
    if_instr = 0;
    wb_set(1, 0, 32'd99);
    tick();
    wb_set(0, 0, 0);
    n_cmp++;
    if (ex_val1 !== 32'd0 || ex_val2 !== 32'd0) begin
      n_fail++; $display("FAIL bypass_r0 got=%0d/%0d exp=0/0", ex_val1, ex_val2);
    end
    // The bypassed write also landed in the array.
    if_instr = enc_r(1, 2, 1, 0);
    tick();
    if_instr = 0;
    tick();
    $display("r1 after write-back reads %0d", ex_val1);
    n_cmp++;
    if (ex_val1 !== 32'd1546) begin
      n_fail++; $display("FAIL bypass_persist got=%0d exp=1546", ex_val1);
    end
  endtask

  task automatic test_bne();
    wb_set(1, 1, 32'd3); tick();
    wb_set(1, 3, 32'd1); tick();
    wb_set(0, 0, 0);
    if_pc = 32'd360; if_instr = enc_i(41, 3, 1, -41);
    tick();
    $display("BNE r1,r3,-41 @360 r1=3 r3=1: taken=%0b addr=%0d", br_taken, br_addr);
    n_cmp++;
    if (br_taken !== 1'b1 || br_addr !== 32'd200) begin
      n_fail++; $display("FAIL bne_taken got=%0b/%0d exp=1/200", br_taken, br_addr);
    end
    // Wrong-path fetch that must be squashed.
    if_pc = 32'd364; if_instr = enc_i(32, 9, 0, 5);
    tick();
    if_instr = 0;
    n_cmp++;
    if (br_taken !== 1'b0 || ex_wb_en !== 1'b0 || ex_mem_r !== 1'b0 || ex_mem_w !== 1'b0) begin
      n_fail++; $display("FAIL bne_in_ex got=t%0b w%0b r%0b m%0b exp=t0 w0 r0 m0", br_taken, ex_wb_en, ex_mem_r, ex_mem_w);
    end
    tick();
    n_cmp++;
    if (ex_wb_en !== 1'b0 || ex_dest !== 5'd0) begin
      n_fail++; $display("FAIL bne_flush got=w%0b d%0d exp=w0 d0", ex_wb_en, ex_dest);
    end
    // Not taken: r3 becomes 3 via write-back in the same cycle as the compare.
    if_pc = 32'd360; if_instr = enc_i(41, 3, 1, -41);
    tick();
    if_instr = 0;
    wb_set(1, 3, 32'd3);
    #1;
    $display("BNE r1,r3 with wb r3=3 bypassed: taken=%0b", br_taken);
    n_cmp++;
    if (br_taken !== 1'b0) begin
      n_fail++; $display("FAIL bne_not_taken_bypass got=%0b exp=0", br_taken);
    end
    tick();
    wb_set(0, 0, 0);
    if_instr = enc_i(41, 3, 1, -41);
    tick();
    if_instr = 0;
    n_cmp++;
    if (br_taken !== 1'b0) begin
      n_fail++; $display("FAIL bne_not_taken got=%0b exp=0", br_taken);
    end
    tick();
  endtask

  task automatic test_bez_jmp();
    if_pc = 32'd116; if_instr = enc_i(40, 0, 5, 1);
    tick();
    if_instr = 0;
    $display("BEZ r5,1 @116 r5=0: taken=%0b addr=%0d", br_taken, br_addr);
    n_cmp++;
    if (br_taken !== 1'b1 || br_addr !== 32'd124) begin
      n_fail++; $display("FAIL bez_taken got=%0b/%0d exp=1/124", br_taken, br_addr);
    end
    tick();
    wb_set(1, 5, 32'd9); tick(); wb_set(0, 0, 0);
    if_instr = enc_i(40, 0, 5, 1);
    tick();
    if_instr = 0;
    n_cmp++;
    if (br_taken !== 1'b0) begin
      n_fail++; $display("FAIL bez_not_taken got=%0b exp=0", br_taken);
    end
    tick();
    if_pc = 32'd464; if_instr = enc_i(42, 0, 0, -1);
    tick();
    if_instr = 0;
    $display("JMP -1 @464: taken=%0b addr=%0d", br_taken, br_addr);
    n_cmp++;
    if (br_taken !== 1'b1 || br_addr !== 32'd464) begin
      n_fail++; $display("FAIL jmp got=%0b/%0d exp=1/464", br_taken, br_addr);
    end
    tick();
  endtask

  task automatic test_r0_ld_st();
    wb_set(1, 0, 32'd5); tick(); wb_set(0, 0, 0);
    if_instr = enc_r(1, 2, 0, 0);
    tick();
    if_instr = 0;
    tick();
    n_cmp++;
    if (ex_val1 !== 32'd0 || ex_val2 !== 32'd0) begin
      n_fail++; $display("FAIL r0_guard got=%0d/%0d exp=0/0", ex_val1, ex_val2);
    end
    wb_set(1, 5, 32'd7); tick(); wb_set(0, 0, 0);
    if_instr = enc_i(36, 5, 8, -4);
    tick();
    if_instr = enc_i(37, 5, 8, -4);
    tick();
    if_instr = 0;
    $display("LD r5,r8,-4: val2=%h mem_r=%0b dest=%0d", ex_val2, ex_mem_r, ex_dest);
    n_cmp++;
    if (ex_val2 !== 32'hFFFFFFFC || ex_mem_r !== 1'b1 || ex_dest !== 5'd5 || ex_wb_en !== 1'b1 || ex_mem_w !== 1'b0 || ex_cmd !== 4'd0) begin
      n_fail++; $display("FAIL ld got=v%h r%0b d%0d w%0b m%0b c%0d exp=vFFFFFFFC r1 d5 w1 m0 c0", ex_val2, ex_mem_r, ex_dest, ex_wb_en, ex_mem_w, ex_cmd);
    end
    tick();
    $display("ST r5,r8,-4 r5=7: st_val=%0d mem_w=%0b wb_en=%0b", ex_st_val, ex_mem_w, ex_wb_en);
    n_cmp++;
    if (ex_st_val !== 32'd7 || ex_mem_w !== 1'b1 || ex_wb_en !== 1'b0 || ex_mem_r !== 1'b0 || ex_val2 !== 32'hFFFFFFFC) begin
      n_fail++; $display("FAIL st got=s%0d m%0b w%0b r%0b v%h exp=s7 m1 w0 r0 vFFFFFFFC", ex_st_val, ex_mem_w, ex_wb_en, ex_mem_r, ex_val2);
    end
  endtask

  task automatic test_random(input int n);
    int ops [21] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42, 2, 13, 50};
    int op;
    for (int c = 0; c < n; c++) begin
      op = ops[$urandom_range(20, 0)];
      if_pc    = $urandom & 32'hFFFF_FFFC;
      if_instr = {6'(op), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 16'($urandom)};
      case ($urandom_range(3, 0))
        0:       wb_set(0, 0, 0);
        1:       wb_set(1, $urandom_range(7, 0), 32'd0);
        2:       wb_set(1, $urandom_range(7, 0), 32'($urandom_range(3, 0)));
        default: wb_set(1, $urandom_range(31, 0), $urandom);
      endcase
      #1;
      n_cmp++;
      if (br_taken !== m_br_taken()) begin
        n_fail++; $display("FAIL rnd_br_taken cyc=%0d got=%0b exp=%0b", c, br_taken, m_br_taken());
      end
      if (m_br_taken()) begin
        n_cmp++;
        if (br_addr !== m_br_addr()) begin
          n_fail++; $display("FAIL rnd_br_addr cyc=%0d got=%h exp=%h", c, br_addr, m_br_addr());
        end
      end
      tick();
      $display("rnd %0d instr=%h ex: v1=%h v2=%h st=%h d=%0d c=%0d w%0b r%0b m%0b", c, if_instr,
               ex_val1, ex_val2, ex_st_val, ex_dest, ex_cmd, ex_wb_en, ex_mem_r, ex_mem_w);
      n_cmp++;
      if (ex_wb_en !== m_ex.wb_en || ex_mem_r !== m_ex.mem_r || ex_mem_w !== m_ex.mem_w) begin
        n_fail++; $display("FAIL rnd_ctrl cyc=%0d got=%b%b%b exp=%b%b%b", c, ex_wb_en, ex_mem_r, ex_mem_w, m_ex.wb_en, m_ex.mem_r, m_ex.mem_w);
      end
      if (m_ex.chk_dest) begin
        n_cmp++;
        if (ex_dest !== m_ex.dest) begin
          n_fail++; $display("FAIL rnd_dest cyc=%0d got=%0d exp=%0d", c, ex_dest, m_ex.dest);
        end
      end
      if (m_ex.chk_cmd) begin
        n_cmp++;
        if (ex_cmd !== m_ex.cmd) begin
          n_fail++; $display("FAIL rnd_cmd cyc=%0d got=%0d exp=%0d", c, ex_cmd, m_ex.cmd);
        end
      end
      if (m_ex.chk_val1) begin
        n_cmp++;
        if (ex_val1 !== m_ex.val1) begin
          n_fail++; $display("FAIL rnd_val1 cyc=%0d got=%h exp=%h", c, ex_val1, m_ex.val1);
        end
      end
      if (m_ex.chk_val2) begin
        n_cmp++;
        if (ex_val2 !== m_ex.val2) begin
          n_fail++; $display("FAIL rnd_val2 cyc=%0d got=%h exp=%h", c, ex_val2, m_ex.val2);
        end
      end
      if (m_ex.chk_st) begin
        n_cmp++;
        if (ex_st_val !== m_ex.st_val) begin
          n_fail++; $display("FAIL rnd_st_val cyc=%0d got=%h exp=%h", c, ex_st_val, m_ex.st_val);
        end
      end
    end
    wb_set(0, 0, 0);
    if_instr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    if_pc = 0; if_instr = 0;
    wb_en = 0; wb_dest = 0; wb_value = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_addi();
    test_bypass();
    test_bne();
    test_bez_jmp();
    test_r0_ld_st();
    test_random(400);
    test_reset();
    test_random(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage MIPS-style pipeline. It sits directly downstream of instruction fetch and owns three things: the IF/ID pipeline register, the 32×32 register file with its write-back port, and the ID/EX pipeline register. It decodes the team's custom ISA and resolves BEZ, BNE and JMP in ID, returning `br_taken` and `br_addr` to fetch.

## Interface
- No parameters.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `if_pc` in 32: fetch PC (address of `if_instr`).
- `if_instr` in 32: fetched instruction.
- `wb_en` in 1: register-file write enable from write-back.
- `wb_dest` in 5: write-back destination register.
- `wb_value` in 32: write-back data.
- `br_taken` out 1: branch/jump taken (combinational, to fetch).
- `br_addr` out 32: branch target (combinational, to fetch).
- `ex_pc` out 32: registered PC of the instruction in EX.
- `ex_val1` out 32: registered operand 1 (value of rs1).
- `ex_val2` out 32: registered operand 2 (value of rs2, or sign-extended imm).
- `ex_st_val` out 32: registered store data.
- `ex_dest` out 5: registered destination register.
- `ex_cmd` out 4: registered ALU command.
- `ex_wb_en` out 1: registered write-back enable.
- `ex_mem_r` out 1: registered memory read.
- `ex_mem_w` out 1: registered memory write.

## Operation
- **Field layout.**
  - op [31:26], rs1 [25:21], f2 [20:16], rd [15:11], imm [15:0].
  - imm is sign-extended to 32 bits.
- **R-type** (ops 1 ADD, 3 SUB, 5 AND, 6 OR, 7 NOR, 8 XOR, 9 SLA, 10 SLL, 11 SRA, 12 SRL):
  - val1=R[rs1], val2=R[f2], dest=rd, wb_en=1.
- **ADDI (32) / SUBI (33):**
  - val1=R[rs1], val2=sext(imm), dest=f2, wb_en=1.
  - Command is ADD or SUB respectively.
- **LD (36):**
  - val1=R[rs1], val2=sext(imm), dest=f2, cmd=ADD, wb_en=1, mem_r=1.
- **ST (37):**
  - val1=R[rs1], val2=sext(imm), st_val=R[f2], cmd=ADD, mem_w=1, wb_en=0.
- **Branches and jump:**
  - BEZ (40) is taken when R[rs1]==0.
  - BNE (41) is taken when R[rs1]!=R[f2].
  - JMP (42) is always taken.
  - br_addr = id_pc + 4 + (sext(imm) << 2), computed in 32-bit wrap-around arithmetic.
  - Branches write nothing: wb_en=0, mem_r=0, mem_w=0.
- **Op 0 and undefined opcodes** decode as a bubble: wb_en, mem_r, mem_w all 0, cmd=ADD, dest=0.
- **Register file.**
  - r0 reads 0 always; writes to r0 are discarded.
  - Write occurs on the posedge when wb_en=1.
  - A read of wb_dest during the same cycle returns wb_value (write-first bypass). The bypass does not apply when wb_dest=0.
- **IF/ID register.**
  - Captures if_pc and if_instr every posedge.
  - When br_taken=1, it captures instruction 0 (NOP) instead, flushing the single wrong-path fetch. The captured PC value is don't-care.
- **ID/EX register.** Captures the decoded fields every posedge. There is no stall path.

## Timing
- **Reset:**
  - IF/ID, ID/EX and all 32 registers clear to 0.
  - Every ex_* output is 0.
  - br_taken=0, because a NOP sits in ID.
- **Latency:**
  - An instruction on if_instr at edge N is in ID after N.
  - Its ex_* outputs are valid after edge N+1.
- **Branch timing:**
  - br_taken and br_addr are valid in the same cycle the branch is in ID.
  - Fetch loads br_addr at the next edge, while ID simultaneously takes a NOP.
  - Net penalty is one bubble.
- **Simultaneous write-back and read of the same register:** the bypass value is used for both operands and for the branch compare.
- **Reset asserted mid-operation:** it clears state immediately. Any pending branch is dropped.

## Structure
- Shared package `isa_pkg` holds:
  - opcode constants;
  - the 4-bit ALU command encoding: ADD 0, SUB 1, AND 2, OR 3, NOR 4, XOR 5, SLA 6, SLL 7, SRA 8, SRL 9;
  - field bit positions.
- One sub-module, `reg_file`: 32×32, two combinational read ports, one write port, r0 hardwired, write-first bypass.
- Decode, branch compare and both pipeline registers live in `id_stage`.

## Test plan
1. **Reset.** Assert rst mid-run → all ex_* outputs 0, br_taken=0; R[1..31] read back 0.
2. **ADDI decode.** if_instr=0x8001060A (ADDI r1,r0,1546) → two edges later: ex_val1=0, ex_val2=1546, ex_dest=1, ex_cmd=ADD, ex_wb_en=1.
3. **Write-back bypass.** wb_en=1, wb_dest=1, wb_value=1546 in the same cycle ADD r2,r0,r1 is in ID → ex_val2=1546.
4. **BNE taken / not taken, with flush.**
   - BNE r1,r3,-41 at PC 360 with r1=3, r3=1 → br_taken=1, br_addr=200; the next ID content is NOP.
   - With r3=3 → br_taken=0.
5. **BEZ and JMP.**
   - BEZ r5,1 at PC 116 with r5=0 → br_addr=124.
   - JMP -1 at PC 464 → br_taken=1, br_addr=464.
6. **r0 guard, LD, ST.**
   - Write-back r0←5 → R[0] reads 0.
   - LD r5,r8,-4 → ex_val2=0xFFFFFFFC, ex_mem_r=1, ex_dest=5.
   - ST r5,r8,-4 with r5=7 → ex_st_val=7, ex_mem_w=1, ex_wb_en=0.
